// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DW_DEFAULT  : default divisor/remainder width (dividend/quotient are twice this).
//   CNT_W       : bit-counter width for the default width.
//   div_state_t : controller states.
package div_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned CNT_W      = $clog2(2 * DW_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem_i     : partial remainder R (DW+1 bits; the MSB is always 0 between steps)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   rem_o     : updated partial remainder
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int unsigned DW = 8
) (
  input  logic [DW:0]   rem_i,
  input  logic          bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW:0]   rem_o,
  output logic          q_o
);

  logic [DW:0] shifted;
  logic [DW:0] diff;

  // The incoming MSB is shifted out by construction, so it never matters.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_i[DW];

  always_comb begin
    shifted = {rem_i[DW-1:0], bit_i};
    // DW+1-bit compare/subtract: shifted < 2*divisor, so this cannot overflow.
    diff    = shifted - {1'b0, divisor_i};
    q_o     = (shifted >= {1'b0, divisor_i});
    rem_o   = q_o ? diff : shifted;
  end

endmodule

// File: rtl/seq_divider_16x8.sv
// Sequential restoring divider, one quotient bit per clock behind a
// start/busy/done handshake. Divide-by-zero completes in one cycle with an
// all-ones quotient and the low dividend byte as remainder.
// Ports:
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   start_i       : request a division (sampled only when idle)
//   dividend_i    : numerator, 2*DW bits, captured on accept
//   divisor_i     : denominator, DW bits, captured on accept
//   busy_o        : high while computing or presenting the result
//   done_o        : one-cycle result-valid pulse
//   quotient_o    : quotient, held until the next result
//   remainder_o   : remainder, held until the next result
//   div_by_zero_o : divisor was zero, held like the results
module seq_divider_16x8
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2*DW-1:0] dividend_i,
  input  logic [DW-1:0]   divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [2*DW-1:0] quotient_o,
  output logic [DW-1:0]   remainder_o,
  output logic            div_by_zero_o
);

  localparam int unsigned CntW = $clog2(2 * DW);
  localparam logic [CntW-1:0] CntLast = CntW'(2 * DW - 1);

  div_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Holds the dividend; quotient bits enter at the LSB as dividend bits leave the MSB.
  logic [2*DW-1:0] shift_q, shift_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DW:0]     rem_q, rem_d;
  logic [2*DW-1:0] quot_q, quot_d;
  logic [DW-1:0]   remd_q, remd_d;
  logic            dbz_q, dbz_d;

  logic [DW:0]     step_rem;
  logic            step_q;

  div_step #(
    .DW (DW)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (shift_q[2*DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_d = dividend_i;
          dvs_d   = divisor_i;
          rem_d   = '0;
          cnt_d   = CntLast;
          if (divisor_i == '0) begin
            state_d = DONE;
            quot_d  = '1;
            remd_d  = dividend_i[DW-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        shift_d = {shift_q[2*DW-2:0], step_q};
        rem_d   = step_rem;
        if (cnt_q == '0) begin
          // Results are loaded on the edge into DONE so they are valid with done_o.
          state_d = DONE;
          quot_d  = {shift_q[2*DW-2:0], step_q};
          remd_d  = step_rem[DW-1:0];
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
    end
  end

  // All outputs come straight from registers.
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign quotient_o    = quot_q;
  assign remainder_o   = remd_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Self-checking bench for seq_divider_16x8: a cycle-level result model built on
// plain / and % plus accept/done cycle bookkeeping, a per-cycle compare process,
// and directed vectors with literal expected values.
module tb_seq_divider_16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dvd;
  logic [7:0]  dvs;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [7:0]  remd;
  logic        dbz;

  always #5 clk = ~clk;

  seq_divider_16x8 #(
    .DW (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .dividend_i    (dvd),
    .divisor_i     (dvs),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quot),
    .remainder_o   (remd),
    .div_by_zero_o (dbz)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cyc is the index of the current clock cycle; an operation accepted in
  // cycle acc is busy through cycle dcyc, where done is shown.
  int          cyc  = 0;
  int          acc  = -100;
  int          dcyc = -100;
  logic [15:0] pq, eq = '0;
  logic [7:0]  pr, er = '0;
  logic        pz, ez = 1'b0;
  logic [15:0] tmp16;

  always @(posedge clk) begin
    if (rst) begin
      acc  = -100;
      dcyc = -100;
      eq   = '0;
      er   = '0;
      ez   = 1'b0;
    end else if (start && !((cyc > acc) && (cyc <= dcyc))) begin
      acc = cyc;
      if (dvs == 8'd0) begin
        pq   = 16'hFFFF;
        pr   = dvd[7:0];
        pz   = 1'b1;
        dcyc = cyc + 1;
      end else begin
        pq    = dvd / {8'd0, dvs};
        tmp16 = dvd % {8'd0, dvs};
        pr    = tmp16[7:0];
        pz    = 1'b0;
        dcyc  = cyc + 17;
      end
    end
    cyc++;
    if (cyc == dcyc) begin
      eq = pq;
      er = pr;
      ez = pz;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy), 32'((cyc > acc) && (cyc <= dcyc)));
      check("done", 32'(done), 32'(cyc == dcyc));
      check("quotient", 32'(quot), 32'(eq));
      check("remainder", 32'(remd), 32'(er));
      check("div_by_zero", 32'(dbz), 32'(ez));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input logic [15:0] xq,
                        input logic [7:0] xr, input logic xz, input int lat);
    int t0;
    bit seen;
    start = 1'b1;
    dvd   = a;
    dvs   = b;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    dvd   = 16'($urandom);
    dvs   = 8'($urandom);
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(cyc - t0), 32'(lat));
      check("lit_quotient", 32'(quot), 32'(xq));
      check("lit_remainder", 32'(remd), 32'(xr));
      check("lit_div_by_zero", 32'(dbz), 32'(xz));
    end
    @(negedge clk);
  endtask

  logic [15:0] tv_a [11] = '{16'd100, 16'd1000, 16'd48, 16'd324, 16'd528, 16'd1001,
                             16'd65535, 16'd65535, 16'd5, 16'd1234, 16'd100};
  logic [7:0]  tv_b [11] = '{8'd10, 8'd20, 8'd6, 8'd18, 8'd24, 8'd10,
                             8'd255, 8'd1, 8'd7, 8'd0, 8'd10};
  logic [15:0] tv_q [11] = '{16'd10, 16'd50, 16'd8, 16'd18, 16'd22, 16'd100,
                             16'd257, 16'd65535, 16'd0, 16'hFFFF, 16'd10};
  logic [7:0]  tv_r [11] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1,
                             8'd0, 8'd0, 8'd5, 8'hD2, 8'd0};
  logic        tv_z [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int nd;
    int prev;
    logic [15:0] cq;
    logic [7:0]  cr;

    rst   = 1'b1;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quot), 32'd0);
    check("rst_remainder", 32'(remd), 32'd0);
    check("rst_div_by_zero", 32'(dbz), 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Directed vectors, including divide-by-zero and the flag clearing afterwards.
    for (int i = 0; i < 11; i++) begin
      do_div(tv_a[i], tv_b[i], tv_q[i], tv_r[i], tv_z[i], (tv_b[i] == 8'd0) ? 1 : 17);
    end

    // Start while busy is ignored: one done, first operation's result.
    start = 1'b1;
    dvd   = 16'd528;
    dvs   = 8'd24;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    dvd   = 16'd777;
    dvs   = 8'd3;
    @(negedge clk);
    start = 1'b0;
    nd    = 0;
    cq    = '0;
    cr    = '0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        nd++;
        cq = quot;
        cr = remd;
      end
      @(negedge clk);
    end
    check("busy_start_done_count", 32'(nd), 32'd1);
    check("busy_start_quotient", 32'(cq), 32'd22);
    check("busy_start_remainder", 32'(cr), 32'd0);

    // Reset mid-operation, then start on the first post-reset cycle.
    start = 1'b1;
    dvd   = 16'd1000;
    dvs   = 8'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quot), 32'd0);
    check("abort_remainder", 32'(remd), 32'd0);
    check("abort_div_by_zero", 32'(dbz), 32'd0);
    do_div(16'd324, 8'd18, 16'd18, 8'd0, 1'b0, 17);

    // Back-to-back random operands with start held high.
    start = 1'b1;
    dvd   = 16'($urandom);
    dvs   = 8'($urandom_range(255, 1));
    prev  = -1;
    nd    = 0;
    for (int k = 0; k < 2000 * 18; k++) begin
      @(negedge clk);
      if (done) begin
        if (prev >= 0) check("issue_interval", 32'(cyc - prev), 32'd18);
        prev = cyc;
        nd++;
      end
      dvd = 16'($urandom);
      dvs = 8'($urandom_range(255, 1));
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("random_done_count", 32'(nd), 32'd2000);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
